// File: rtl/conv_frame_sequencer.sv
// conv_frame_sequencer: start/done frame controller for the image_loader -> RGB_Process -> conv_kernel -> image_dumper path
module conv_frame_sequencer #(
    parameter int WIDTH         = 640,
    parameter int HEIGHT        = 480,
    parameter int COORD_W       = 13,
    parameter int KERNEL_WIDTH  = 4,
    parameter int OUT_PIXELS    = 307200,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [2:0]                mode_i,
    input  logic                      in_valid,
    input  logic                      out_valid,
    output logic                      src_en,
    output logic [COORD_W-1:0]        row_o,
    output logic [COORD_W-1:0]        col_o,
    output logic [9*KERNEL_WIDTH-1:0] kernel_o,
    output logic                      sof_o,
    output logic                      eol_o,
    output logic                      eof_o,
    output logic                      busy_o,
    output logic                      done_o,
    output logic                      err_o,
    output logic [15:0]               frame_cnt
);
    localparam int OUT_W   = $clog2(OUT_PIXELS + 1);
    localparam int DRAIN_W = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] ROW_LAST  = COORD_W'(HEIGHT - 1);
    localparam logic [OUT_W-1:0]   OUT_MAX   = OUT_W'(OUT_PIXELS);
    localparam logic [DRAIN_W-1:0] DRAIN_END = DRAIN_W'(DRAIN_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t             state, state_nxt;
    logic [OUT_W-1:0]   out_cnt, out_cnt_nxt;
    logic [DRAIN_W-1:0] drain_cnt;
    logic               accept, last_pix, out_inc, out_full, timeout, start_ok;

    // coeff[r][c] packed row-major, index 0 is the top-left tap
    function automatic logic [9*KERNEL_WIDTH-1:0] kern(input logic [2:0] m);
        int k [9];
        logic [9*KERNEL_WIDTH-1:0] v;
        case (m)
            3'd1:    k = '{ 1,  1,  1,  1, 1,  1,  1,  1,  1};
            3'd2:    k = '{-1,  0,  1, -2, 0,  2, -1,  0,  1};
            3'd3:    k = '{-1, -2, -1,  0, 0,  0,  1,  2,  1};
            3'd4:    k = '{ 0, -1,  0, -1, 5, -1,  0, -1,  0};
            default: k = '{ 0,  0,  0,  0, 1,  0,  0,  0,  0};
        endcase
        v = '0;
        for (int i = 0; i < 9; i++) v[i*KERNEL_WIDTH +: KERNEL_WIDTH] = k[i][KERNEL_WIDTH-1:0];
        return v;
    endfunction

    assign src_en = (state == RUN);
    assign busy_o = (state != IDLE);

    // Accept/count qualifiers and next state; counting completion beats the timeout
    always_comb begin
        start_ok    = (state == IDLE) && start;
        accept      = (state == RUN) && in_valid;
        last_pix    = accept && (row_o == ROW_LAST) && (col_o == COL_LAST);
        out_inc     = (state != IDLE) && out_valid && (out_cnt != OUT_MAX);
        out_cnt_nxt = out_inc ? out_cnt + 1'b1 : out_cnt;
        out_full    = (state == DRAIN) && (out_cnt_nxt == OUT_MAX);
        timeout     = (state == DRAIN) && !out_full && (drain_cnt == DRAIN_END);
        state_nxt   = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = last_pix ? DRAIN : RUN;
            DRAIN:   state_nxt = (out_full || timeout) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // State, pixel coordinates, kernel latch, output counting and status flags
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            row_o     <= '0;
            col_o     <= '0;
            kernel_o  <= kern(3'd0);
            sof_o     <= 1'b0;
            eol_o     <= 1'b0;
            eof_o     <= 1'b0;
            done_o    <= 1'b0;
            err_o     <= 1'b0;
            frame_cnt <= '0;
            out_cnt   <= '0;
            drain_cnt <= '0;
        end else begin
            state     <= state_nxt;
            sof_o     <= accept && (row_o == '0) && (col_o == '0);
            eol_o     <= accept && (col_o == COL_LAST);
            eof_o     <= last_pix;
            done_o    <= out_full || timeout;
            err_o     <= ((state == IDLE) && out_valid) || timeout || (err_o && !start_ok);
            drain_cnt <= (state == DRAIN) ? drain_cnt + 1'b1 : '0;
            out_cnt   <= start_ok ? '0 : out_cnt_nxt;
            if (start_ok) kernel_o <= kern(mode_i);
            if (out_full) frame_cnt <= frame_cnt + 16'd1;
            if (accept) begin
                col_o <= (col_o == COL_LAST) ? '0 : col_o + 1'b1;
                row_o <= last_pix ? '0 : (col_o == COL_LAST) ? row_o + 1'b1 : row_o;
            end
        end
    end
endmodule

// File: tb/tb_conv_frame_sequencer.sv
// tb_conv_frame_sequencer: randomized frames checked against a pixel-index reference model
module tb_conv_frame_sequencer;
    localparam int W  = 4;
    localparam int H  = 3;
    localparam int NO = 12;
    localparam int TO = 20;

    logic        clk = 1'b0;
    logic        reset = 1'b1, start = 1'b0, in_valid = 1'b0, out_valid = 1'b0;
    logic [2:0]  mode_i = 3'd0;
    logic        src_en, sof_o, eol_o, eof_o, busy_o, done_o, err_o;
    logic [12:0] row_o, col_o;
    logic [35:0] kernel_o;
    logic [15:0] frame_cnt;

    int errors = 0, checks = 0;
    int m_ph = 0, m_pix = 0, m_outs = 0, m_dc = 0, m_frames = 0, m_k = 0;
    bit m_err = 0, m_sof = 0, m_eol = 0, m_eof = 0, m_done = 0;

    conv_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .COORD_W(13), .KERNEL_WIDTH(4),
                           .OUT_PIXELS(NO), .DRAIN_TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .start(start), .mode_i(mode_i), .in_valid(in_valid),
        .out_valid(out_valid), .src_en(src_en), .row_o(row_o), .col_o(col_o),
        .kernel_o(kernel_o), .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o), .busy_o(busy_o),
        .done_o(done_o), .err_o(err_o), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Kernel taps derived from each filter's geometric definition
    function automatic logic [35:0] kref(input int m);
        logic [35:0] v;
        int k;
        v = '0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++) begin
                case (m)
                    1:       k = 1;
                    2:       k = (c - 1) * ((r == 1) ? 2 : 1);
                    3:       k = (r - 1) * ((c == 1) ? 2 : 1);
                    4:       k = (r == 1 && c == 1) ? 5 : (((r == 1) != (c == 1)) ? -1 : 0);
                    default: k = (r == 1 && c == 1) ? 1 : 0;
                endcase
                v[(r*3+c)*4 +: 4] = k[3:0];
            end
        return v;
    endfunction

    task automatic step(input logic st, input logic [2:0] md, input logic iv, input logic ov, input logic rs);
        start = st; mode_i = md; in_valid = iv; out_valid = ov; reset = rs;
        @(posedge clk); #1;
        if (rs) begin
            m_ph = 0; m_pix = 0; m_outs = 0; m_dc = 0; m_frames = 0; m_k = 0;
            m_err = 0; m_sof = 0; m_eol = 0; m_eof = 0; m_done = 0;
        end else begin
            m_sof = 0; m_eol = 0; m_eof = 0; m_done = 0;
            if (m_ph == 0) begin
                if (st) begin m_k = md; m_outs = 0; m_err = 0; m_ph = 1; end
                if (ov) m_err = 1;
            end else if (m_ph == 1) begin
                if (ov && m_outs < NO) m_outs++;
                if (iv) begin
                    m_sof = (m_pix == 0);
                    m_eol = (m_pix % W == W - 1);
                    m_eof = (m_pix == W*H - 1);
                    m_pix++;
                    if (m_pix == W*H) begin m_pix = 0; m_ph = 2; m_dc = 0; end
                end
            end else begin
                if (ov && m_outs < NO) m_outs++;
                if (m_outs == NO) begin m_ph = 0; m_done = 1; m_frames = (m_frames + 1) % 65536; end
                else if (m_dc == TO - 1) begin m_ph = 0; m_done = 1; m_err = 1; end
                else m_dc++;
            end
        end
        check("src_en", src_en, m_ph == 1);
        check("busy", busy_o, m_ph != 0);
        check("row", row_o, m_pix / W);
        check("col", col_o, m_pix % W);
        check("sof", sof_o, m_sof);
        check("eol", eol_o, m_eol);
        check("eof", eof_o, m_eof);
        check("done", done_o, m_done);
        check("err", err_o, m_err);
        check("frame_cnt", frame_cnt, m_frames);
        check("kernel", kernel_o, kref(m_k));
    endtask

    // One frame: random input gaps plus stray start/mode changes while busy
    task automatic frame(input logic [2:0] m, input int n_out);
        int acc, outs, dn, eols, eofs, guard;
        logic iv, ov;
        acc = 0; outs = 0; dn = 0; eols = 0; eofs = 0; guard = 0;
        step(1'b1, m, 1'b0, 1'b0, 1'b0);
        while (acc < W*H) begin
            iv = ($urandom_range(0, 2) != 0);
            ov = iv && (outs < n_out) && (outs < NO - 3);
            step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), iv, ov, 1'b0);
            if (iv) acc++;
            if (ov) outs++;
            dn += int'(done_o); eols += int'(eol_o); eofs += int'(eof_o);
        end
        while (guard < 2*TO && m_ph != 0) begin
            ov = (outs < n_out) && ($urandom_range(0, 1) == 1);
            step($urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), ov, 1'b0);
            if (ov) outs++;
            guard++;
            dn += int'(done_o); eols += int'(eol_o); eofs += int'(eof_o);
        end
        check("done_count", dn, 1);
        check("eol_count", eols, H);
        check("eof_count", eofs, 1);
        if (n_out < NO) check("drain_len", guard, TO);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
        repeat (5) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        check("kernel_identity", kernel_o, 36'h000010000);
        frame(3'd3, NO);
        check("frame_cnt_after_first", frame_cnt, 1);
        frame(3'd1, NO);
        check("kernel_box", kernel_o, 36'h111111111);
        frame(3'd0, 5);
        frame(3'd4, NO);
        step(1'b0, 3'd0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        frame(3'd2, NO);
        step(1'b1, 3'd4, 1'b0, 1'b0, 1'b0);
        repeat (6) step(1'b0, 3'd4, 1'b1, 1'b1, 1'b0);
        check("mid_row", row_o, 1);
        check("mid_col", col_o, 2);
        step(1'b0, 3'd4, 1'b1, 1'b1, 1'b1);
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
        frame(3'd4, NO);
        for (int i = 0; i < 6; i++) frame(3'($urandom_range(0, 7)), $urandom_range(4, NO));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
